// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and the IR/datapath.
// The controller drives through 'master'; the datapath side uses 'slave'.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic                ir_write;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [1:0]          alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                reg_write;
    logic                reg_dst;
    logic [1:0]          pc_src;
    logic                exception;
    logic [1:0]          exc_cause;
    logic [3:0]          state;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               pc_src, exception, exc_cause, state
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               pc_src, exception, exc_cause, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// bounded memory-ready wait and precise illegal-opcode / timeout exceptions.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        WB_MEM   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        JR       = 4'd13,
        EXC      = 4'd14
    } state_e;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic [1:0] pcSrc;
        logic       exception;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_SLTIU = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_LBU   = OPCODE_W'(36);
    localparam logic [OPCODE_W-1:0] OP_LHU   = OPCODE_W'(37);
    localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'(40);
    localparam logic [OPCODE_W-1:0] OP_SH    = OPCODE_W'(41);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(43);
    localparam logic [FUNCT_W-1:0]  FN_JR    = FUNCT_W'(8);
    localparam logic [CNT_W-1:0]    WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]       cause_q, cause_d;
    ctrl_t            ctrl_q;
    logic             isLoad, isStore, fetchDone;

    function automatic ctrl_t decodeState(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.memRead = 1'b1; c.aluSrcB = 2'b01; end
            DECODE:   c.aluSrcB = 2'b11;
            EXEC_R:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            WB_R:     begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            EXEC_I:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
            WB_I:     c.regWrite = 1'b1;
            MEM_ADDR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEM_RD:   begin c.memRead = 1'b1; c.iOrD = 1'b1; end
            WB_MEM:   begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
            MEM_WR:   begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
            BRANCH:   begin
                c.aluSrcA = 1'b1; c.aluOp = 2'b01;
                c.pcWriteCond = 1'b1; c.pcSrc = 2'b01;
            end
            JUMP:     begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
            JR:       begin c.aluSrcA = 1'b1; c.pcWrite = 1'b1; end
            EXC:      begin c.exception = 1'b1; c.pcWrite = 1'b1; c.pcSrc = 2'b11; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign isLoad  = bus.opcode inside {OP_LW, OP_LBU, OP_LHU};
    assign isStore = bus.opcode inside {OP_SB, OP_SH, OP_SW};

    // The wait states share one policy: a ready in the cycle the counter sits at
    // WAIT_MAX still completes; only a missing ready at that point times out.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        cause_d   = cause_q;
        case (state_q)
            RST:      state_d = FETCH;
            FETCH, MEM_RD, MEM_WR: begin
                if (bus.mem_ready) begin
                    if (state_q == FETCH)       state_d = DECODE;
                    else if (state_q == MEM_RD) state_d = WB_MEM;
                    else                        state_d = FETCH;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d = EXC;
                    cause_d = 2'b10;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                if (bus.opcode == OP_RTYPE && bus.funct == FN_JR)   state_d = JR;
                else if (bus.opcode == OP_RTYPE)                    state_d = EXEC_R;
                else if (bus.opcode inside {OP_ADDI, OP_SLTI, OP_SLTIU,
                                            OP_ANDI, OP_ORI, OP_LUI}) state_d = EXEC_I;
                else if (isLoad || isStore)                         state_d = MEM_ADDR;
                else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) state_d = BRANCH;
                else if (bus.opcode == OP_J)                        state_d = JUMP;
                else begin
                    state_d = EXC;
                    cause_d = 2'b01;
                end
            end
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_I;
            MEM_ADDR: state_d = isLoad ? MEM_RD : MEM_WR;
            default:  state_d = FETCH;
        endcase
        if (state_d != state_q && (state_d == FETCH || state_d == MEM_RD || state_d == MEM_WR))
            waitCnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST;
            waitCnt_q <= '0;
            cause_q   <= 2'b00;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            cause_q   <= cause_d;
            ctrl_q    <= decodeState(state_d);
        end
    end

    assign fetchDone = (state_q == FETCH) && bus.mem_ready;

    assign bus.pc_write      = ctrl_q.pcWrite | fetchDone;
    assign bus.ir_write      = fetchDone;
    assign bus.pc_write_cond = ctrl_q.pcWriteCond;
    assign bus.i_or_d        = ctrl_q.iOrD;
    assign bus.mem_read      = ctrl_q.memRead;
    assign bus.mem_write     = ctrl_q.memWrite;
    assign bus.mem_to_reg    = ctrl_q.memToReg;
    assign bus.alu_op        = ctrl_q.aluOp;
    assign bus.alu_src_a     = ctrl_q.aluSrcA;
    assign bus.alu_src_b     = ctrl_q.aluSrcB;
    assign bus.reg_write     = ctrl_q.regWrite;
    assign bus.reg_dst       = ctrl_q.regDst;
    assign bus.pc_src        = ctrl_q.pcSrc;
    assign bus.exception     = ctrl_q.exception;
    assign bus.exc_cause     = cause_q;
    assign bus.state         = state_q;

endmodule
